// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared widths and FSM encoding for the truth-table sweeper
package truth_table_sweeper_pkg;

  localparam int VEC_W  = 3;
  localparam int TBL_W  = 8;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  // True when idx addresses the final row of the table.
  function automatic logic is_last_vec(input logic [VEC_W-1:0] idx);
    return idx == VEC_W'(TBL_W - 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_step_counter.sv
// rtl/truth_table_sweeper_step_counter.sv - settle wait counter and vector index
module tts_step_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             count,
  input  logic             advance,
  output logic [VEC_W-1:0] idx,
  output logic             settle_done
);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [VEC_W-1:0]  idx_q, idx_d;

  // Next-state: clear restarts a sweep, advance moves to the next row, count ticks the settle wait.
  always_comb begin
    wait_d = wait_q;
    idx_d  = idx_q;
    if (clear) begin
      wait_d = '0;
      idx_d  = '0;
    end else if (advance) begin
      wait_d = '0;
      if (!is_last_vec(idx_q)) idx_d = idx_q + VEC_W'(1);
    end else if (count && !settle_done) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      idx_q  <= '0;
    end else begin
      wait_q <= wait_d;
      idx_q  <= idx_d;
    end
  end

  assign idx         = idx_q;
  assign settle_done = (wait_q == WAIT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives all 3-input vectors and captures the function's truth table
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int               SETTLE      = 1,
  parameter logic [TBL_W-1:0] EXP_DEFAULT = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [TBL_W-1:0] expected,
  output logic [VEC_W-1:0] vec_out,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] result,
  output logic [TBL_W-1:0] mismatch,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [TBL_W-1:0] exp_q, exp_d;
  logic [TBL_W-1:0] result_q, result_d;
  logic             pass_q, pass_d;
  logic             cnt_clear, cnt_count, cnt_advance;
  logic [VEC_W-1:0] idx;
  logic             settle_done;

  tts_step_counter #(
    .SETTLE(SETTLE)
  ) u_step (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .count      (cnt_count),
    .advance    (cnt_advance),
    .idx        (idx),
    .settle_done(settle_done)
  );

  // Next-state and datapath updates; abort takes priority over every other action.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    result_d    = result_q;
    pass_d      = pass_q;
    cnt_clear   = 1'b0;
    cnt_count   = 1'b0;
    cnt_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = DRIVE;
          exp_d     = expected;
          result_d  = '0;
          pass_d    = 1'b0;
          cnt_clear = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          cnt_count = 1'b1;
          if (settle_done) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else begin
          result_d[idx] = s_in;
          if (is_last_vec(idx)) begin
            state_d = FINISH;
          end else begin
            cnt_advance = 1'b1;
            state_d     = DRIVE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        pass_d  = abort ? 1'b0 : (result_q == exp_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_q    <= EXP_DEFAULT;
      result_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      pass_q   <= pass_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign vec_out  = (state_q == DRIVE || state_q == SAMPLE) ? idx : '0;
  assign result   = result_q;
  assign mismatch = result_q ^ exp_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic       clk;
  logic [1:0] rst_v, start_v, abort_v, s_in_v, busy_v, done_v, pass_v;
  logic [7:0] exp_v[2];
  logic [2:0] vec_v[2];
  logic [7:0] result_v[2];
  logic [7:0] mismatch_v[2];
  logic [7:0] fn_tbl[2];

  int total = 0;
  int bad   = 0;

  truth_table_sweeper #(.SETTLE(1), .EXP_DEFAULT(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .expected(exp_v[0]), .vec_out(vec_v[0]), .s_in(s_in_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .result(result_v[0]), .mismatch(mismatch_v[0]), .pass(pass_v[0])
  );

  truth_table_sweeper #(.SETTLE(3), .EXP_DEFAULT(8'hA5)) dut3 (
    .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .expected(exp_v[1]), .vec_out(vec_v[1]), .s_in(s_in_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .result(result_v[1]), .mismatch(mismatch_v[1]), .pass(pass_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External function under test: a lookup of the current vector in a table.
  always_comb begin
    s_in_v[0] = fn_tbl[0][vec_v[0]];
    s_in_v[1] = fn_tbl[1][vec_v[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int u, input logic [7:0] res, input logic [7:0] ex, input logic ps);
    chk("idle_busy", 32'(busy_v[u]), 0);
    chk("idle_done", 32'(done_v[u]), 0);
    chk("idle_vec", 32'(vec_v[u]), 0);
    chk("idle_result", 32'(result_v[u]), 32'(res));
    chk("idle_mismatch", 32'(mismatch_v[u]), 32'(res ^ ex));
    chk("idle_pass", 32'(pass_v[u]), 32'(ps));
  endtask

  // One sweep; t counts clock edges after the accepting edge, sampled on falling edges.
  task automatic sweep(input int u, input logic [7:0] ex, input int abort_at,
                       input int restart_at, input int rst_at);
    int s, len;
    logic [7:0] part, fn;
    s    = (u == 0) ? 1 : 3;
    len  = 8 * (s + 1);
    part = 8'h00;
    fn   = fn_tbl[u];
    @(negedge clk);
    exp_v[u]   = ex;
    start_v[u] = 1'b1;
    @(negedge clk);
    exp_v[u] = 8'($urandom);
    for (int t = 0; t <= len; t++) begin
      if (t > 0) @(negedge clk);
      start_v[u] = 1'b0;
      if (t == rst_at) begin
        #2 rst_v[u] = 1'b0;
        #1;
        chk_idle(u, 8'h00, 8'hA5, 1'b0);
        @(negedge clk);
        rst_v[u] = 1'b1;
        return;
      end
      chk("sweep_vec", 32'(vec_v[u]), (t < len) ? 32'(t / (s + 1)) : 0);
      chk("sweep_busy", 32'(busy_v[u]), 1);
      chk("sweep_done", 32'(done_v[u]), (t == len) ? 1 : 0);
      if (t == abort_at) begin
        abort_v[u] = 1'b1;
        @(negedge clk);
        abort_v[u] = 1'b0;
        chk_idle(u, part, ex, 1'b0);
        return;
      end
      if (t == restart_at) start_v[u] = 1'b1;
      if (t < len && (t % (s + 1)) == s) part[t / (s + 1)] = fn[t / (s + 1)];
    end
    @(negedge clk);
    chk_idle(u, fn, ex, fn == ex);
  endtask

  initial begin
    logic [7:0] good_fn, ex, held_res;
    logic held_pass;
    int u, ab;
    for (int i = 0; i < 8; i++) good_fn[i] = ~(i[2] ^ i[0]);
    fn_tbl[0] = good_fn;
    fn_tbl[1] = good_fn;
    rst_v   = 2'b00;
    start_v = 2'b00;
    abort_v = 2'b00;
    exp_v[0] = 8'h00;
    exp_v[1] = 8'h00;

    // Reset held for three cycles, then a quiet idle period.
    repeat (3) @(negedge clk);
    chk_idle(0, 8'h00, 8'hA5, 1'b0);
    chk_idle(1, 8'h00, 8'hA5, 1'b0);
    rst_v = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("quiet_busy", 32'(busy_v[0]), 0);
    end

    // Good sweep, then a function with a stuck-at-0 row 5.
    sweep(0, 8'hA5, -1, -1, -1);
    fn_tbl[0] = good_fn & ~8'h20;
    sweep(0, 8'hA5, -1, -1, -1);
    chk("fault_result", 32'(result_v[0]), 32'h85);
    chk("fault_mismatch", 32'(mismatch_v[0]), 32'h20);
    fn_tbl[0] = good_fn;

    // Start pulse while busy is ignored.
    sweep(0, 8'hA5, -1, 5, -1);

    // Abort mid-sweep, outputs hold in idle, then a normal sweep.
    sweep(0, 8'hA5, 7, -1, -1);
    held_res = result_v[0];
    for (int i = 0; i < 4; i++) begin
      fn_tbl[0] = 8'($urandom);
      @(negedge clk);
      chk_idle(0, held_res, 8'hA5, 1'b0);
    end
    fn_tbl[0] = good_fn;
    sweep(0, 8'hA5, -1, -1, -1);

    // Start and abort together in idle: abort wins.
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    exp_v[0]   = 8'h3C;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk_idle(0, good_fn, 8'hA5, 1'b1);

    // Randomized sweeps on both instances against the table model.
    for (int i = 0; i < 8; i++) begin
      u  = int'($urandom_range(0, 1));
      fn_tbl[u] = 8'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? fn_tbl[u] : 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (u == 0) ? 15 : 31)) : -1;
      sweep(u, ex, ab, -1, -1);
      held_res  = result_v[u];
      held_pass = pass_v[u];
      for (int j = 0; j < 2; j++) begin
        fn_tbl[u] = 8'($urandom);
        @(negedge clk);
        chk("hold_result", 32'(result_v[u]), 32'(held_res));
        chk("hold_pass", 32'(pass_v[u]), 32'(held_pass));
      end
    end

    // SETTLE=3: asynchronous reset mid-sweep, then a full sweep.
    fn_tbl[1] = good_fn;
    sweep(1, 8'hA5, -1, -1, 9);
    sweep(1, 8'hA5, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: cycles vec_out is held before s_in is sampled.
REQ-002 SHALL have parameter EXP_DEFAULT, default 8'hA5: value loaded into the expected register at reset.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, ports as follows.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  sweep request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous sweep cancel.
REQ-008 expected  input  8  expected truth table; bit i = expected output for vector i; latched on accepted start.
REQ-009 vec_out  output  3  vector to the function under test; [2]=x, [1]=y, [0]=z.
REQ-010 s_in  input  1  output of the function under test.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at sweep completion.
REQ-013 result  output  8  captured table; bit i = s_in sampled for vector i.
REQ-014 mismatch  output  8  result XOR latched expected, combinational from registers.
REQ-015 pass  output  1  registered: high when the last completed sweep had mismatch == 0.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FINISH.
REQ-017 IDLE: start=1 -> latch expected, idx=0, result=0, pass=0, wait=0; go to DRIVE.
REQ-018 DRIVE: vec_out=idx; wait counter increments each cycle; after SETTLE cycles in DRIVE, go to SAMPLE.
REQ-019 SAMPLE: result[idx] <= s_in; idx==7 -> FINISH; otherwise idx+1, wait=0, go to DRIVE.
REQ-020 FINISH: done=1 for exactly this cycle; pass <= (result==expected_latched); go to IDLE.
REQ-021 Latency: start accepted at edge k -> done high in cycle k+1+8*(SETTLE+1); SETTLE=1 -> done 17 cycles after start edge.
REQ-022 vec_out SHALL equal 3'b000 in IDLE and FINISH, and idx in DRIVE and SAMPLE.
REQ-023 idx SHALL be 3 bits; it is never incremented past 7 (no wrap inside a sweep).
REQ-024 start while busy SHALL be ignored; the sweep in progress is unaffected.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, pass=0, result retains partial bits.
REQ-026 abort and start both high in IDLE -> abort wins; no sweep starts.
REQ-027 result, pass, and latched expected SHALL hold their values in IDLE until the next accepted start.
REQ-028 s_in SHALL be sampled only in SAMPLE; its value in other states has no effect.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, idx=0, wait=0, vec_out=0, busy=0, done=0, result=0, pass=0, expected_latched=EXP_DEFAULT.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse; operation resumes on the first clk edge after rst_n rises.

Structure
REQ-031 A shared package SHALL hold the state enum encoding (IDLE=0, DRIVE=1, SAMPLE=2, FINISH=3), the vector width (3), and the table width (8).
REQ-032 The settle counter plus idx SHALL form one sub-module, tts_step_counter, with clear/advance controls and a settle_done output.
REQ-033 The function under test SHALL be external; this block only drives vec_out and reads s_in.

Verification
REQ-034 Reset then idle: rst_n low 3 cycles -> all outputs 0; start=0 for 10 cycles -> busy stays 0.
REQ-035 Good sweep: SETTLE=1, s_in = ~(vec_out[2]^vec_out[0]), expected=8'hA5, start pulse -> vec_out steps 0..7, done at +17 cycles, result=8'hA5, mismatch=0, pass=1.
REQ-036 Faulty DUT: s_in forced 0 for vector 5, expected=8'hA5 -> result=8'h85, mismatch=8'h20, pass=0.
REQ-037 Start while busy: second start pulse at cycle 6 -> ignored; exactly one done pulse at cycle 17.
REQ-038 Abort: abort at cycle 8 -> busy low next cycle, no done, pass=0, result holds bits sampled so far; new start then completes normally.
REQ-039 Async reset mid-sweep and SETTLE=3: rst_n low at cycle 10 -> outputs clear without a clk edge; after release, a new sweep gives done at +33 cycles.
